cast_ni_packetizer: RTL and testbench

//   Local-port injection network interface: turns a raw payload word stream from the PE into

---
 rtl/cast_ni_packetizer_pkg.sv | 37 +++
 rtl/cast_ni_packetizer_credit_ctr.sv | 33 +++
 rtl/cast_ni_packetizer.sv | 100 ++++++++++
 tb/tb_cast_ni_packetizer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cast_ni_packetizer_pkg.sv
// Shared definitions for the local-port injection packetizer: flit width,
// flit-type codes, head-flit field layout and the FSM state encoding.
package cast_ni_packetizer_pkg;

  // Flit width; the top two bits carry the flit type, the rest is payload.
  localparam int DW = 48;
  localparam int PW = DW - 2;

  localparam logic [1:0] FT_HEAD = 2'b00;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;

  // Head flit: {type, dst_x, dst_y, src_x, src_y, seq, zero pad}.
  localparam int HF_W      = 8;
  localparam int DST_X_LSB = DW - 2 - HF_W;
  localparam int DST_Y_LSB = DST_X_LSB - HF_W;
  localparam int SRC_X_LSB = DST_Y_LSB - HF_W;
  localparam int SRC_Y_LSB = SRC_X_LSB - HF_W;
  localparam int SEQ_LSB   = SRC_Y_LSB - HF_W;
  localparam int PAD_W     = SEQ_LSB;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  function automatic logic [DW-1:0] make_head(
    input logic [HF_W-1:0] dst_x,
    input logic [HF_W-1:0] dst_y,
    input logic [HF_W-1:0] src_x,
    input logic [HF_W-1:0] src_y,
    input logic [HF_W-1:0] seq
  );
    return {FT_HEAD, dst_x, dst_y, src_x, src_y, seq, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cast_ni_packetizer_credit_ctr.sv
// End-to-end packet credit counter. A head load consumes one credit, a
// returned-credit pulse gives one back; both in the same cycle cancel out.
// A return while already full saturates and latches a sticky error.
module cast_ni_packetizer_credit_ctr #(
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       take,
  output logic [3:0] credits,
  output logic       err
);

  localparam logic [3:0] CMAX = 4'(CREDITS);

  // Credit count and sticky overflow flag; take is only raised when credits != 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CMAX;
      err     <= 1'b0;
    end else if (inc && !take) begin
      if (credits == CMAX) begin
        err <= 1'b1;
      end else begin
        credits <= credits + 4'd1;
      end
    end else if (take && !inc) begin
      credits <= credits - 4'd1;
    end
  end

endmodule

// File: rtl/cast_ni_packetizer.sv
// Local-port injection network interface. Wraps a raw payload word stream
// into HEAD/BODY/TAIL flits for the router local input, prepending one head
// flit with routing info and gating each packet on an end-to-end credit.
//
// Handshake: both the payload input (pay_valid_i/pay_ready_o) and the flit
// output (flit_valid_o/flit_ready_i) transfer on a cycle where valid & ready
// are both high; a valid once raised holds its data stable until it transfers.
module cast_ni_packetizer
  import cast_ni_packetizer_pkg::*;
#(
  parameter int x_pos   = 0,
  parameter int y_pos   = 0,
  parameter int PL      = 16,
  parameter int CREDITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pay_valid_i,
  input  logic [PW-1:0] pay_data_i,
  output logic          pay_ready_o,
  input  logic [7:0]    dst_x_i,
  input  logic [7:0]    dst_y_i,
  input  logic          credit_inc_i,
  output logic          flit_valid_o,
  output logic [DW-1:0] flit_data_o,
  input  logic          flit_ready_i,
  output logic [3:0]    credits_o,
  output logic          err_o,
  output logic          state_o
);

  localparam logic [7:0] SRC_X = 8'(x_pos);
  localparam logic [7:0] SRC_Y = 8'(y_pos);
  localparam logic [7:0] LAST  = 8'(PL - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] seq;
  logic       slot_free;
  logic       head_load;
  logic       pay_accept;

  // The single output slot can take a new flit when empty or draining this cycle.
  assign slot_free   = !flit_valid_o || flit_ready_i;
  assign head_load   = (state == ST_IDLE) && pay_valid_i && (credits_o != 4'd0) && slot_free;
  assign pay_ready_o = (state == ST_PAYLOAD) && slot_free;
  assign pay_accept  = pay_valid_i && pay_ready_o;
  assign state_o     = logic'(state);

  cast_ni_packetizer_credit_ctr #(
    .CREDITS(CREDITS)
  ) u_credit_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (credit_inc_i),
    .take   (head_load),
    .credits(credits_o),
    .err    (err_o)
  );

  // Packet FSM and output flit slot; the head is emitted without consuming a payload word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      flit_valid_o <= 1'b0;
      flit_data_o  <= '0;
      cnt          <= 8'd0;
      seq          <= 8'd0;
    end else begin
      if (flit_valid_o && flit_ready_i) begin
        flit_valid_o <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (head_load) begin
            flit_valid_o <= 1'b1;
            flit_data_o  <= make_head(dst_x_i, dst_y_i, SRC_X, SRC_Y, seq);
            seq          <= seq + 8'd1;
            cnt          <= 8'd0;
            state        <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pay_accept) begin
            flit_valid_o <= 1'b1;
            cnt          <= cnt + 8'd1;
            if (cnt == LAST) begin
              flit_data_o <= {FT_TAIL, pay_data_i};
              state       <= ST_IDLE;
            end else begin
              flit_data_o <= {FT_BODY, pay_data_i};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cast_ni_packetizer.sv
// Bench for cast_ni_packetizer: PL=4, CREDITS=4, node (1,0).
module tb_cast_ni_packetizer;
  import cast_ni_packetizer_pkg::DW;
  import cast_ni_packetizer_pkg::PW;

  localparam int PL = 4;
  localparam int CREDITS = 4;
  localparam logic [7:0] SRC_X = 8'd1;
  localparam logic [7:0] SRC_Y = 8'd0;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pay_valid_i = 1'b0;
  logic [PW-1:0] pay_data_i = '0;
  logic          pay_ready_o;
  logic [7:0]    dst_x_i = 8'd0;
  logic [7:0]    dst_y_i = 8'd0;
  logic          credit_inc_i = 1'b0;
  logic          flit_valid_o;
  logic [DW-1:0] flit_data_o;
  logic          flit_ready_i = 1'b1;
  logic [3:0]    credits_o;
  logic          err_o;
  logic          state_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cast_ni_packetizer #(
    .x_pos(1), .y_pos(0), .PL(PL), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .rst(rst),
    .pay_valid_i(pay_valid_i), .pay_data_i(pay_data_i), .pay_ready_o(pay_ready_o),
    .dst_x_i(dst_x_i), .dst_y_i(dst_y_i), .credit_inc_i(credit_inc_i),
    .flit_valid_o(flit_valid_o), .flit_data_o(flit_data_o), .flit_ready_i(flit_ready_i),
    .credits_o(credits_o), .err_o(err_o), .state_o(state_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            fire_cyc[$];
  int            n_fire = 0;
  logic [7:0]    m_seq = 8'd0;
  bit            abort = 1'b0;
  int            last_start = 0;

  // Every flit transfer is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && flit_valid_o && flit_ready_i) begin
      if (exp_q.size() == 0) check("unexpected_flit", 64'(flit_data_o), 64'hDEAD);
      else check("flit", 64'(flit_data_o), 64'(exp_q.pop_front()));
      fire_cyc.push_back(cyc);
      n_fire++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_packet(input logic [7:0] dx, input logic [7:0] dy);
    logic [PW-1:0] words[PL];
    logic [63:0]   r;
    bit            acc;
    exp_q.push_back({2'b00, dx, dy, SRC_X, SRC_Y, m_seq, 6'd0});
    m_seq = m_seq + 8'd1;
    for (int i = 0; i < PL; i++) begin
      r = {$urandom(), $urandom()};
      words[i] = r[PW-1:0];
      exp_q.push_back({(i == PL-1) ? 2'b10 : 2'b01, words[i]});
    end
    dst_x_i = dx;
    dst_y_i = dy;
    last_start = cyc;
    for (int i = 0; i < PL && !abort; i++) begin
      pay_valid_i = 1'b1;
      pay_data_i = words[i];
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc && !abort; t++) begin
        @(negedge clk);
        acc = pay_ready_o;
        @(posedge clk);
        #1;
      end
      if (!acc && !abort) begin
        check("pay_accept_timeout", 64'd0, 64'd1);
        break;
      end
      // Routing inputs changing mid-packet must not affect the head.
      dst_x_i = 8'($urandom());
      dst_y_i = 8'($urandom());
    end
    pay_valid_i = 1'b0;
  endtask

  task automatic credit_pulse();
    credit_inc_i = 1'b1;
    @(posedge clk);
    #1;
    credit_inc_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fires(input int target);
    for (int t = 0; t < 200 && n_fire < target; t++) begin
      @(negedge clk);
      #1;
    end
    if (n_fire < target) check("fire_timeout", 64'(n_fire), 64'(target));
  endtask

  // ---------------- main sequence ----------------
  logic [DW-1:0] hold;
  int            b;
  bit            done;

  initial begin
    // Reset state
    #23;
    check("rst_valid", 64'(flit_valid_o), 64'd0);
    check("rst_data", 64'(flit_data_o), 64'd0);
    check("rst_pay_ready", 64'(pay_ready_o), 64'd0);
    check("rst_credits", 64'(credits_o), 64'd4);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // One packet to (3,2), continuous ready: five consecutive flits.
    b = n_fire;
    send_packet(8'd3, 8'd2);
    wait_drain();
    check("t1_fire_count", 64'(n_fire - b), 64'd5);
    if (fire_cyc.size() >= b + 5) begin
      check("t1_head_latency", 64'(fire_cyc[b]), 64'(last_start + 1));
      for (int i = 1; i < 5; i++)
        check("t1_back_to_back", 64'(fire_cyc[b+i]), 64'(fire_cyc[b] + i));
    end
    check("t1_credits", 64'(credits_o), 64'd3);

    // Backpressure for three cycles mid-packet.
    b = n_fire;
    fork
      send_packet(8'd5, 8'd6);
      begin
        wait_fires(b + 2);
        @(posedge clk);
        #1;
        flit_ready_i = 1'b0;
        hold = flit_data_o;
        check("stall_valid", 64'(flit_valid_o), 64'd1);
        repeat (3) begin
          @(negedge clk);
          check("stall_data", 64'(flit_data_o), 64'(hold));
          check("stall_pay_ready", 64'(pay_ready_o), 64'd0);
        end
        @(posedge clk);
        #1;
        flit_ready_i = 1'b1;
      end
    join
    wait_drain();
    check("t2_credits", 64'(credits_o), 64'd2);

    // Credit return coinciding with head load leaves the count unchanged.
    fork
      send_packet(8'd4, 8'd4);
      begin
        credit_pulse();
        @(negedge clk);
        check("coinc_head_valid", 64'(flit_valid_o), 64'd1);
        check("coinc_credits", 64'(credits_o), 64'd2);
      end
    join
    wait_drain();
    credit_pulse();
    credit_pulse();
    @(negedge clk);
    check("refill_credits", 64'(credits_o), 64'd4);
    check("refill_err", 64'(err_o), 64'd0);

    // Return while full: saturate and set the sticky error.
    @(posedge clk);
    #1;
    credit_pulse();
    @(negedge clk);
    check("ovf_credits", 64'(credits_o), 64'd4);
    check("ovf_err", 64'(err_o), 64'd1);
    @(posedge clk);
    #1;

    // Exhaust all credits; the next head stalls until a credit returns.
    for (int p = 0; p < CREDITS; p++) send_packet(8'(p), 8'(p + 1));
    wait_drain();
    check("exh_credits", 64'(credits_o), 64'd0);
    fork
      send_packet(8'd7, 8'd8);
      begin
        repeat (5) begin
          @(negedge clk);
          check("exh_no_head", 64'(flit_valid_o), 64'd0);
        end
        check("exh_state", 64'(state_o), 64'd0);
        @(posedge clk);
        #1;
        credit_pulse();
        @(negedge clk);
        check("exh_credit_back", 64'(credits_o), 64'd1);
        check("exh_still_no_head", 64'(flit_valid_o), 64'd0);
        @(negedge clk);
        check("exh_head_now", 64'(flit_valid_o), 64'd1);
        check("exh_credits_zero", 64'(credits_o), 64'd0);
      end
    join
    wait_drain();
    repeat (CREDITS) credit_pulse();
    check("err_sticky", 64'(err_o), 64'd1);

    // Random backpressure across several packets with random routing.
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 3; p++) send_packet(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          flit_ready_i = 1'($urandom_range(0, 1));
        end
        flit_ready_i = 1'b1;
      end
    join
    wait_drain();
    repeat (3) credit_pulse();
    check("rand_credits", 64'(credits_o), 64'd4);

    // Enough packets for the sequence number to wrap 255 -> 0.
    for (int p = 0; p < 257; p++) begin
      send_packet(8'(p), 8'(255 - p));
      credit_pulse();
    end
    wait_drain();
    check("wrap_seq_model", 64'(m_seq < 8'd20), 64'd1);

    // Reset after the second body flit: abandon the packet.
    b = n_fire;
    fork
      send_packet(8'd9, 8'd9);
      begin
        wait_fires(b + 3);
        rst = 1'b1;
        abort = 1'b1;
        #1;
        check("mid_rst_valid", 64'(flit_valid_o), 64'd0);
        check("mid_rst_data", 64'(flit_data_o), 64'd0);
        check("mid_rst_pay_ready", 64'(pay_ready_o), 64'd0);
        check("mid_rst_credits", 64'(credits_o), 64'd4);
        check("mid_rst_err", 64'(err_o), 64'd0);
      end
    join
    exp_q.delete();
    m_seq = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    b = n_fire;
    send_packet(8'd2, 8'd1);
    wait_drain();
    check("post_rst_fires", 64'(n_fire - b), 64'd5);
    check("post_rst_credits", 64'(credits_o), 64'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
